// File: rtl/exu_ctrl_pkg.sv
// Shared types and constants for the execute-stage sequencing controller.
package exu_ctrl_pkg;

    // Controller states: idle, waiting on the iterative MDU, or holding a result for the LSU.
    typedef enum logic [1:0] {
        EXU_ST_IDLE     = 2'd0,
        EXU_ST_WAIT_MDU = 2'd1,
        EXU_ST_HOLD     = 2'd2
    } exu_state_e;

    localparam int EXU_STALL_W = 32;

endpackage

// File: rtl/exu_ctrl_sat_counter.sv
// Saturating up-counter with enable; stops at all-ones instead of wrapping.
module exu_ctrl_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: increment when enabled unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/exu_ctrl.sv
// Execute-stage sequencing controller: accepts one decoded instruction at a
// time, captures single-cycle results directly or waits on the external MDU,
// and holds the finished result for the LSU handshake.
module exu_ctrl
    import exu_ctrl_pkg::*;
#(
    parameter int XLEN          = 64,
    parameter int REG_ADDRWIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     idu_valid_i,
    output logic                     idu_ready_o,
    input  logic                     is_muldiv_i,
    input  logic [REG_ADDRWIDTH-1:0] rd_idx_i,
    input  logic [XLEN-1:0]          alu_result_i,
    input  logic                     flush_i,
    output logic                     mdu_start_o,
    output logic                     mdu_kill_o,
    input  logic                     mdu_done_i,
    input  logic [XLEN-1:0]          mdu_result_i,
    output logic                     lsu_valid_o,
    input  logic                     lsu_ready_i,
    output logic [XLEN-1:0]          ex_result_o,
    output logic [REG_ADDRWIDTH-1:0] ex_rd_idx_o,
    output logic [31:0]              stall_cnt_o
);

    exu_state_e               state_q, state_d;
    logic [XLEN-1:0]          result_q, result_d;
    logic [REG_ADDRWIDTH-1:0] rd_q, rd_d;
    logic                     accept;
    logic                     stall_en;

    // Next-state, datapath capture and handshake outputs.
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        rd_d        = rd_q;
        idu_ready_o = ((state_q == EXU_ST_IDLE) ||
                       ((state_q == EXU_ST_HOLD) && lsu_ready_i)) && !flush_i;
        accept      = idu_valid_i && idu_ready_o;
        lsu_valid_o = (state_q == EXU_ST_HOLD) && !flush_i;
        mdu_start_o = accept && is_muldiv_i;
        mdu_kill_o  = (state_q == EXU_ST_WAIT_MDU) && flush_i;

        if (flush_i) begin
            // Flush squashes everything, including a same-cycle MDU completion.
            state_d = EXU_ST_IDLE;
        end else begin
            case (state_q)
                EXU_ST_IDLE, EXU_ST_HOLD: begin
                    if (accept) begin
                        rd_d = rd_idx_i;
                        if (is_muldiv_i) begin
                            state_d = EXU_ST_WAIT_MDU;
                        end else begin
                            result_d = alu_result_i;
                            state_d  = EXU_ST_HOLD;
                        end
                    end else if ((state_q == EXU_ST_HOLD) && lsu_ready_i) begin
                        state_d = EXU_ST_IDLE;
                    end
                end
                EXU_ST_WAIT_MDU: begin
                    if (mdu_done_i) begin
                        result_d = mdu_result_i;
                        state_d  = EXU_ST_HOLD;
                    end
                end
                default: begin
                    state_d = EXU_ST_IDLE;
                end
            endcase
        end
    end

    // State and result/destination registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EXU_ST_IDLE;
            result_q <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            rd_q     <= rd_d;
        end
    end

    // A stall cycle is any cycle spent waiting on the MDU or on the LSU.
    assign stall_en = (state_q == EXU_ST_WAIT_MDU) ||
                      ((state_q == EXU_ST_HOLD) && !lsu_ready_i);

    exu_ctrl_sat_counter #(
        .W (EXU_STALL_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (stall_en),
        .cnt_o (stall_cnt_o)
    );

    assign ex_result_o = result_q;
    assign ex_rd_idx_o = rd_q;

endmodule

// File: tb/tb_exu_ctrl.sv
// Directed self-checking bench for exu_ctrl.
module tb_exu_ctrl;

    localparam int XLEN = 64;
    localparam int RW   = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            idu_valid_i;
    logic            idu_ready_o;
    logic            is_muldiv_i;
    logic [RW-1:0]   rd_idx_i;
    logic [XLEN-1:0] alu_result_i;
    logic            flush_i;
    logic            mdu_start_o;
    logic            mdu_kill_o;
    logic            mdu_done_i;
    logic [XLEN-1:0] mdu_result_i;
    logic            lsu_valid_o;
    logic            lsu_ready_i;
    logic [XLEN-1:0] ex_result_o;
    logic [RW-1:0]   ex_rd_idx_o;
    logic [31:0]     stall_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    exu_ctrl #(.XLEN(XLEN), .REG_ADDRWIDTH(RW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .idu_valid_i  (idu_valid_i),
        .idu_ready_o  (idu_ready_o),
        .is_muldiv_i  (is_muldiv_i),
        .rd_idx_i     (rd_idx_i),
        .alu_result_i (alu_result_i),
        .flush_i      (flush_i),
        .mdu_start_o  (mdu_start_o),
        .mdu_kill_o   (mdu_kill_o),
        .mdu_done_i   (mdu_done_i),
        .mdu_result_i (mdu_result_i),
        .lsu_valid_o  (lsu_valid_o),
        .lsu_ready_i  (lsu_ready_i),
        .ex_result_o  (ex_result_o),
        .ex_rd_idx_o  (ex_rd_idx_o),
        .stall_cnt_o  (stall_cnt_o)
    );

    task automatic test_reset();
        rst_n = 1'b0; idu_valid_i = 1'b0; is_muldiv_i = 1'b0; rd_idx_i = '0;
        alu_result_i = '0; flush_i = 1'b0; mdu_done_i = 1'b0; mdu_result_i = '0;
        lsu_ready_i = 1'b1;
        #2;
        n_cmp++; if (idu_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_idu_ready: got %0b want 1", idu_ready_o); end
        n_cmp++; if (lsu_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_lsu_valid: got %0b want 0", lsu_valid_o); end
        n_cmp++; if (mdu_start_o !== 1'b0) begin n_err++; $display("FAIL rst_mdu_start: got %0b want 0", mdu_start_o); end
        n_cmp++; if (mdu_kill_o !== 1'b0) begin n_err++; $display("FAIL rst_mdu_kill: got %0b want 0", mdu_kill_o); end
        n_cmp++; if (ex_result_o !== 64'h0) begin n_err++; $display("FAIL rst_result: got %0h want 0", ex_result_o); end
        n_cmp++; if (ex_rd_idx_o !== 5'd0) begin n_err++; $display("FAIL rst_rd: got %0d want 0", ex_rd_idx_o); end
        n_cmp++; if (stall_cnt_o !== 32'd0) begin n_err++; $display("FAIL rst_stall: got %0d want 0", stall_cnt_o); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_alu_single();
        @(negedge clk);
        idu_valid_i = 1'b1; is_muldiv_i = 1'b0; alu_result_i = 64'h1234; rd_idx_i = 5'd5;
        lsu_ready_i = 1'b1; mdu_done_i = 1'b1; mdu_result_i = 64'hFFFF; // stray done in IDLE
        #1;
        n_cmp++; if (idu_ready_o !== 1'b1) begin n_err++; $display("FAIL alu_idu_ready: got %0b want 1", idu_ready_o); end
        n_cmp++; if (mdu_start_o !== 1'b0) begin n_err++; $display("FAIL alu_no_start: got %0b want 0", mdu_start_o); end
        @(negedge clk);
        idu_valid_i = 1'b0; mdu_done_i = 1'b0;
        #1;
        n_cmp++; if (lsu_valid_o !== 1'b1) begin n_err++; $display("FAIL alu_lsu_valid: got %0b want 1", lsu_valid_o); end
        n_cmp++; if (ex_result_o !== 64'h1234) begin n_err++; $display("FAIL alu_result: got %0h want 1234", ex_result_o); end
        n_cmp++; if (ex_rd_idx_o !== 5'd5) begin n_err++; $display("FAIL alu_rd: got %0d want 5", ex_rd_idx_o); end
        @(negedge clk);
        #1;
        n_cmp++; if (lsu_valid_o !== 1'b0) begin n_err++; $display("FAIL alu_lsu_drop: got %0b want 0", lsu_valid_o); end
        n_cmp++; if (stall_cnt_o !== 32'd0) begin n_err++; $display("FAIL alu_stall: got %0d want 0", stall_cnt_o); end
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0] vals [4];
        vals[0] = 64'h11; vals[1] = 64'h22; vals[2] = 64'h33; vals[3] = 64'h44;
        lsu_ready_i = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i < 4) begin
                idu_valid_i = 1'b1; is_muldiv_i = 1'b0; alu_result_i = vals[i]; rd_idx_i = RW'(i + 1);
            end else begin
                idu_valid_i = 1'b0;
            end
            #1;
            n_cmp++; if (idu_ready_o !== 1'b1) begin n_err++; $display("FAIL b2b_idu_ready[%0d]: got %0b want 1", i, idu_ready_o); end
            if (i > 0) begin
                n_cmp++; if (lsu_valid_o !== 1'b1) begin n_err++; $display("FAIL b2b_lsu_valid[%0d]: got %0b want 1", i, lsu_valid_o); end
                n_cmp++; if (ex_result_o !== vals[i-1]) begin n_err++; $display("FAIL b2b_result[%0d]: got %0h want %0h", i, ex_result_o, vals[i-1]); end
                n_cmp++; if (ex_rd_idx_o !== RW'(i)) begin n_err++; $display("FAIL b2b_rd[%0d]: got %0d want %0d", i, ex_rd_idx_o, i); end
            end
        end
        @(negedge clk);
        #1;
        n_cmp++; if (lsu_valid_o !== 1'b0) begin n_err++; $display("FAIL b2b_end_valid: got %0b want 0", lsu_valid_o); end
        n_cmp++; if (stall_cnt_o !== 32'd0) begin n_err++; $display("FAIL b2b_stall: got %0d want 0", stall_cnt_o); end
    endtask

    task automatic test_mul();
        int starts = 0;
        @(negedge clk);
        idu_valid_i = 1'b1; is_muldiv_i = 1'b1; rd_idx_i = 5'd7; alu_result_i = 64'hBAD;
        lsu_ready_i = 1'b1;
        #1;
        n_cmp++; if (mdu_start_o !== 1'b1) begin n_err++; $display("FAIL mul_start: got %0b want 1", mdu_start_o); end
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            idu_valid_i = 1'b0;
            mdu_done_i = (k == 8); mdu_result_i = 64'hDEAD;
            #1;
            if (mdu_start_o) starts++;
            n_cmp++; if (idu_ready_o !== 1'b0) begin n_err++; $display("FAIL mul_idu_ready[%0d]: got %0b want 0", k, idu_ready_o); end
            n_cmp++; if (lsu_valid_o !== 1'b0) begin n_err++; $display("FAIL mul_lsu_valid[%0d]: got %0b want 0", k, lsu_valid_o); end
        end
        n_cmp++; if (starts !== 0) begin n_err++; $display("FAIL mul_extra_starts: got %0d want 0", starts); end
        @(negedge clk);
        mdu_done_i = 1'b0;
        #1;
        n_cmp++; if (lsu_valid_o !== 1'b1) begin n_err++; $display("FAIL mul_lsu_valid: got %0b want 1", lsu_valid_o); end
        n_cmp++; if (ex_result_o !== 64'hDEAD) begin n_err++; $display("FAIL mul_result: got %0h want dead", ex_result_o); end
        n_cmp++; if (ex_rd_idx_o !== 5'd7) begin n_err++; $display("FAIL mul_rd: got %0d want 7", ex_rd_idx_o); end
        n_cmp++; if (stall_cnt_o !== 32'd8) begin n_err++; $display("FAIL mul_stall: got %0d want 8", stall_cnt_o); end
        @(negedge clk);
        #1;
        n_cmp++; if (lsu_valid_o !== 1'b0) begin n_err++; $display("FAIL mul_lsu_drop: got %0b want 0", lsu_valid_o); end
    endtask

    task automatic test_hold_stall();
        @(negedge clk);
        idu_valid_i = 1'b1; is_muldiv_i = 1'b0; alu_result_i = 64'h55AA; rd_idx_i = 5'd9;
        lsu_ready_i = 1'b0;
        #1;
        n_cmp++; if (idu_ready_o !== 1'b1) begin n_err++; $display("FAIL hold_accept: got %0b want 1", idu_ready_o); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            alu_result_i = 64'h6666; rd_idx_i = 5'd10; lsu_ready_i = 1'b0;
            #1;
            n_cmp++; if (lsu_valid_o !== 1'b1) begin n_err++; $display("FAIL hold_valid[%0d]: got %0b want 1", c, lsu_valid_o); end
            n_cmp++; if (idu_ready_o !== 1'b0) begin n_err++; $display("FAIL hold_idu_ready[%0d]: got %0b want 0", c, idu_ready_o); end
            n_cmp++; if (ex_result_o !== 64'h55AA) begin n_err++; $display("FAIL hold_result[%0d]: got %0h want 55aa", c, ex_result_o); end
            n_cmp++; if (ex_rd_idx_o !== 5'd9) begin n_err++; $display("FAIL hold_rd[%0d]: got %0d want 9", c, ex_rd_idx_o); end
        end
        @(negedge clk);
        lsu_ready_i = 1'b1;
        #1;
        n_cmp++; if (idu_ready_o !== 1'b1) begin n_err++; $display("FAIL hold_release_ready: got %0b want 1", idu_ready_o); end
        n_cmp++; if (lsu_valid_o !== 1'b1) begin n_err++; $display("FAIL hold_release_valid: got %0b want 1", lsu_valid_o); end
        n_cmp++; if (ex_result_o !== 64'h55AA) begin n_err++; $display("FAIL hold_release_result: got %0h want 55aa", ex_result_o); end
        n_cmp++; if (stall_cnt_o !== 32'd11) begin n_err++; $display("FAIL hold_stall: got %0d want 11", stall_cnt_o); end
        @(negedge clk);
        idu_valid_i = 1'b0;
        #1;
        n_cmp++; if (lsu_valid_o !== 1'b1) begin n_err++; $display("FAIL hold_next_valid: got %0b want 1", lsu_valid_o); end
        n_cmp++; if (ex_result_o !== 64'h6666) begin n_err++; $display("FAIL hold_next_result: got %0h want 6666", ex_result_o); end
        n_cmp++; if (ex_rd_idx_o !== 5'd10) begin n_err++; $display("FAIL hold_next_rd: got %0d want 10", ex_rd_idx_o); end
        n_cmp++; if (stall_cnt_o !== 32'd11) begin n_err++; $display("FAIL hold_next_stall: got %0d want 11", stall_cnt_o); end
    endtask

    task automatic test_flush();
        int kills = 0;
        @(negedge clk);
        idu_valid_i = 1'b1; is_muldiv_i = 1'b1; rd_idx_i = 5'd3; lsu_ready_i = 1'b1;
        for (int w = 1; w <= 4; w++) begin
            @(negedge clk);
            idu_valid_i = 1'b0;
            flush_i = (w == 4);
            #1;
            if (mdu_kill_o) kills++;
            n_cmp++; if (lsu_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_wait_valid[%0d]: got %0b want 0", w, lsu_valid_o); end
        end
        n_cmp++; if (kills !== 1) begin n_err++; $display("FAIL flush_kill_count: got %0d want 1", kills); end
        n_cmp++; if (mdu_kill_o !== 1'b1) begin n_err++; $display("FAIL flush_kill_cycle: got %0b want 1", mdu_kill_o); end
        @(negedge clk);
        flush_i = 1'b0; mdu_done_i = 1'b1; mdu_result_i = 64'hBEEF;
        #1;
        n_cmp++; if (mdu_kill_o !== 1'b0) begin n_err++; $display("FAIL flush_kill_after: got %0b want 0", mdu_kill_o); end
        n_cmp++; if (idu_ready_o !== 1'b1) begin n_err++; $display("FAIL flush_idle_ready: got %0b want 1", idu_ready_o); end
        n_cmp++; if (lsu_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_late_done_valid: got %0b want 0", lsu_valid_o); end
        @(negedge clk);
        mdu_done_i = 1'b0;
        #1;
        n_cmp++; if (lsu_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_no_valid: got %0b want 0", lsu_valid_o); end
        n_cmp++; if (ex_result_o !== 64'h6666) begin n_err++; $display("FAIL flush_result_kept: got %0h want 6666", ex_result_o); end
        n_cmp++; if (stall_cnt_o !== 32'd15) begin n_err++; $display("FAIL flush_stall: got %0d want 15", stall_cnt_o); end
        // flush while holding an ALU result drops it
        idu_valid_i = 1'b1; is_muldiv_i = 1'b0; alu_result_i = 64'h99; rd_idx_i = 5'd4;
        @(negedge clk);
        idu_valid_i = 1'b0; flush_i = 1'b1;
        #1;
        n_cmp++; if (lsu_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_hold_valid: got %0b want 0", lsu_valid_o); end
        n_cmp++; if (idu_ready_o !== 1'b0) begin n_err++; $display("FAIL flush_hold_ready: got %0b want 0", idu_ready_o); end
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        n_cmp++; if (lsu_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_hold_after: got %0b want 0", lsu_valid_o); end
        n_cmp++; if (idu_ready_o !== 1'b1) begin n_err++; $display("FAIL flush_hold_idle: got %0b want 1", idu_ready_o); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        idu_valid_i = 1'b1; is_muldiv_i = 1'b1; rd_idx_i = 5'd12; lsu_ready_i = 1'b1;
        for (int w = 1; w <= 4; w++) begin
            @(negedge clk);
            idu_valid_i = 1'b0;
        end
        #1;
        n_cmp++; if (stall_cnt_o !== 32'd3) begin n_err++; $display("FAIL rmid_stall_pre: got %0d want 3", stall_cnt_o); end
        n_cmp++; if (idu_ready_o !== 1'b0) begin n_err++; $display("FAIL rmid_ready_pre: got %0b want 0", idu_ready_o); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (stall_cnt_o !== 32'd0) begin n_err++; $display("FAIL rmid_stall: got %0d want 0", stall_cnt_o); end
        n_cmp++; if (idu_ready_o !== 1'b1) begin n_err++; $display("FAIL rmid_ready: got %0b want 1", idu_ready_o); end
        n_cmp++; if (ex_rd_idx_o !== 5'd0) begin n_err++; $display("FAIL rmid_rd: got %0d want 0", ex_rd_idx_o); end
        n_cmp++; if (ex_result_o !== 64'h0) begin n_err++; $display("FAIL rmid_result: got %0h want 0", ex_result_o); end
        n_cmp++; if (lsu_valid_o !== 1'b0 || mdu_kill_o !== 1'b0 || mdu_start_o !== 1'b0) begin n_err++; $display("FAIL rmid_ctrl: got v%0b k%0b s%0b want 000", lsu_valid_o, mdu_kill_o, mdu_start_o); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        idu_valid_i = 1'b1; is_muldiv_i = 1'b0; alu_result_i = 64'h77; rd_idx_i = 5'd2;
        @(negedge clk);
        idu_valid_i = 1'b0;
        #1;
        n_cmp++; if (lsu_valid_o !== 1'b1) begin n_err++; $display("FAIL rmid_alu_valid: got %0b want 1", lsu_valid_o); end
        n_cmp++; if (ex_result_o !== 64'h77) begin n_err++; $display("FAIL rmid_alu_result: got %0h want 77", ex_result_o); end
        n_cmp++; if (ex_rd_idx_o !== 5'd2) begin n_err++; $display("FAIL rmid_alu_rd: got %0d want 2", ex_rd_idx_o); end
    endtask

    initial begin
        test_reset();
        test_alu_single();
        test_back_to_back();
        test_mul();
        test_hold_stall();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/exu_ctrl.md
# exu_ctrl

Sequencing controller for the execute stage. It accepts one decoded instruction at a time from decode over a valid/ready handshake. Single-cycle ALU/CSR results are captured directly; multi-cycle mul/div operations are handed to an external iterative MDU and waited on. The finished result and destination index are presented to the LSU over a second valid/ready handshake, with flush support and a stall counter.

## Interface
- `XLEN`, 64, datapath width (taken from `sysconfig.v`)
- `REG_ADDRWIDTH`, 5, register index width
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `idu_valid_i` in 1: decode presents an instruction
- `idu_ready_o` out 1: controller can accept this cycle
- `is_muldiv_i` in 1: instruction needs the MDU
- `rd_idx_i` in REG_ADDRWIDTH: destination register
- `alu_result_i` in XLEN: combinational execute result (ALU or CSR) for the offered instruction
- `flush_i` in 1: squash everything in flight
- `mdu_start_o` out 1: one-cycle MDU start; the MDU samples its operands this cycle
- `mdu_kill_o` out 1: one-cycle MDU abort
- `mdu_done_i` in 1: MDU result valid (single-cycle pulse)
- `mdu_result_i` in XLEN: MDU result
- `lsu_valid_o` out 1: result held for LSU
- `lsu_ready_i` in 1: LSU takes the result
- `ex_result_o` out XLEN: registered result
- `ex_rd_idx_o` out REG_ADDRWIDTH: registered destination
- `stall_cnt_o` out 32: saturating stall-cycle counter

## Operation
- States: IDLE, WAIT_MDU, HOLD.
- `idu_ready_o` = (IDLE | (HOLD & `lsu_ready_i`)) & !`flush_i`.
- accept = `idu_valid_i` & `idu_ready_o`.
- Accept with `is_muldiv_i`=0:
  - latch `alu_result_i` and `rd_idx_i`
  - go to HOLD
- Accept with `is_muldiv_i`=1:
  - `mdu_start_o` = 1 in the same cycle (combinational)
  - latch `rd_idx_i`
  - go to WAIT_MDU
- WAIT_MDU:
  - on `mdu_done_i`: latch `mdu_result_i`, go to HOLD
  - otherwise remain in WAIT_MDU
- HOLD:
  - `lsu_valid_o` = !`flush_i`
  - `ex_result_o` and `ex_rd_idx_o` stay stable until the handshake completes
  - on `lsu_ready_i` with no new accept: go to IDLE
  - on `lsu_ready_i` with an accept: take the new instruction per the rules above (back-to-back)
- Flush:
  - wins over every other event
  - next state is IDLE
  - in WAIT_MDU, `mdu_kill_o` = 1 for that cycle, and a `mdu_done_i` in the same cycle is discarded
  - in HOLD, the result is dropped and never handshaken
- `stall_cnt_o`:
  - +1 on every cycle in WAIT_MDU
  - +1 on every cycle in HOLD with `lsu_ready_i`=0
  - saturates at 0xFFFF_FFFF
  - not cleared by flush
- `mdu_done_i` outside WAIT_MDU is ignored.
- `alu_result_i` is ignored for MDU ops, and `mdu_result_i` is ignored for ALU ops.

## Timing
- Reset (async, immediate):
  - state = IDLE
  - `ex_result_o` = 0, `ex_rd_idx_o` = 0, `stall_cnt_o` = 0
  - `lsu_valid_o` = 0, `mdu_start_o` = 0, `mdu_kill_o` = 0
  - `idu_ready_o` = 1 (when `flush_i` = 0)
- ALU latency: accept in cycle N → `lsu_valid_o` in cycle N+1. Throughput is 1 per cycle while `lsu_ready_i` = 1.
- MDU latency: `mdu_done_i` in cycle M → `lsu_valid_o` in cycle M+1.
- Outputs `lsu_valid_o`, `idu_ready_o`, `mdu_start_o` and `mdu_kill_o` are combinational from state and inputs. All other outputs are registered.
- Reset mid-operation drops any pending MDU op. The controller does not issue a kill; the MDU shares `rst_n`.

## Structure
- State encodings `EXU_ST_IDLE`, `EXU_ST_WAIT_MDU` and `EXU_ST_HOLD` are defined in `sysconfig.v`, alongside the existing `EXCOP_`/`ALUOP_` constants.
- One natural sub-module: `sat_counter` (parameterised width, enable, async active-low reset), used for `stall_cnt_o`.
- The FSM and the result/rd registers stay in `exu_ctrl`.

## Test plan
- ALU op, `alu_result_i`=0x1234, `rd_idx_i`=5, `lsu_ready_i`=1 → next cycle `lsu_valid_o`=1, `ex_result_o`=0x1234, `ex_rd_idx_o`=5; `stall_cnt_o` stays 0.
- Four back-to-back ALU ops, `lsu_ready_i` held 1 → four consecutive `lsu_valid_o` cycles with results in order; `idu_ready_o` stays 1.
- MUL op, `mdu_done_i` after 8 cycles with 0xDEAD → `mdu_start_o` pulses exactly once on the accept cycle, `idu_ready_o`=0 throughout WAIT_MDU, `ex_result_o`=0xDEAD, `stall_cnt_o`=8.
- ALU result held with `lsu_ready_i`=0 for 3 cycles → `ex_result_o` stable, `idu_ready_o`=0, `stall_cnt_o` +3, handshake completes on the 4th cycle.
- `flush_i` in the 4th WAIT_MDU cycle, plus a `mdu_done_i` one cycle later → `mdu_kill_o`=1 for exactly one cycle, state IDLE, no `lsu_valid_o`.
- `rst_n` low mid-WAIT_MDU with `stall_cnt_o`=3 → all outputs take reset values without waiting for a clock edge; after release an ALU op completes normally.
